// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage types and constants
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH_BOOT = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_t;

    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - next fetch address priority mux with alignment/range check
module next_pc_sel
    import mips_pkg::*;
#(
    parameter int IMEM_WORDS = 128
) (
    input  logic [31:0] i_pc_reg,
    input  logic [31:0] i_pc_plus4,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_offset,
    input  logic        i_jump,
    input  logic [25:0] i_jump_target,
    input  logic        i_jump_reg,
    input  logic [31:0] i_jr_target,
    output logic [31:0] o_next_pc,
    output logic        o_err
);

    localparam logic [31:0] ADDR_LIMIT = 32'(IMEM_WORDS * WORD_BYTES);

    logic [31:0] w_seq_pc;
    logic [31:0] w_branch_pc;
    logic [31:0] w_jump_pc;

    // Branch and jump are relative to the delay-slot address, not the fetch address
    assign w_seq_pc    = i_pc_reg + 32'(WORD_BYTES);
    assign w_branch_pc = i_pc_plus4 + (i_branch_offset << 2);
    assign w_jump_pc   = {i_pc_plus4[31:28], i_jump_target, 2'b00};

    always_comb begin
        o_next_pc = w_seq_pc;
        if (i_jump_reg) begin
            o_next_pc = i_jr_target;
        end else if (i_jump) begin
            o_next_pc = w_jump_pc;
        end else if (i_branch_taken) begin
            o_next_pc = w_branch_pc;
        end
    end

    assign o_err = (o_next_pc[1:0] != 2'b00) || (o_next_pc >= ADDR_LIMIT);

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - program counter and instruction-memory address stage
module fetch_pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IMEM_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        halt_req,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jump_reg,
    input  logic [31:0] jr_target,
    output logic [31:0] read_address,
    output logic [31:0] fetch_pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        halted,
    output logic        addr_error
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [31:0] r_pc_reg;
    logic [31:0] r_fetch_pc;
    logic        r_fetch_valid;
    logic        r_halted;
    logic        r_addr_error;

    logic [31:0] w_pc_reg_nxt;
    logic [31:0] w_fetch_pc_nxt;
    logic        w_fetch_valid_nxt;
    logic        w_halted_nxt;
    logic        w_addr_error_nxt;

    logic [31:0] w_sel_pc;
    logic        w_sel_err;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = r_fetch_pc + 32'(WORD_BYTES);

    next_pc_sel #(
        .IMEM_WORDS (IMEM_WORDS)
    ) u_next_pc_sel (
        .i_pc_reg        (r_pc_reg),
        .i_pc_plus4      (w_pc_plus4),
        .i_branch_taken  (branch_taken),
        .i_branch_offset (branch_offset),
        .i_jump          (jump),
        .i_jump_target   (jump_target),
        .i_jump_reg      (jump_reg),
        .i_jr_target     (jr_target),
        .o_next_pc       (w_sel_pc),
        .o_err           (w_sel_err)
    );

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_reg_nxt      = r_pc_reg;
        w_fetch_pc_nxt    = r_fetch_pc;
        w_fetch_valid_nxt = r_fetch_valid;
        w_halted_nxt      = r_halted;
        w_addr_error_nxt  = r_addr_error;
        case (r_state)
            FETCH_BOOT: begin
                w_fetch_pc_nxt    = r_pc_reg;
                w_pc_reg_nxt      = r_pc_reg + 32'(WORD_BYTES);
                w_fetch_valid_nxt = 1'b1;
                w_state_nxt       = FETCH_RUN;
            end
            FETCH_RUN: begin
                if (!stall) begin
                    if (halt_req) begin
                        w_fetch_valid_nxt = 1'b0;
                        w_halted_nxt      = 1'b1;
                        w_state_nxt       = FETCH_HALT;
                    end else if (w_sel_err) begin
                        // The already-requested word moves to fetch_pc; only the bad target is refused
                        w_fetch_pc_nxt    = r_pc_reg;
                        w_fetch_valid_nxt = 1'b0;
                        w_halted_nxt      = 1'b1;
                        w_addr_error_nxt  = 1'b1;
                        w_state_nxt       = FETCH_HALT;
                    end else begin
                        w_fetch_pc_nxt = r_pc_reg;
                        w_pc_reg_nxt   = w_sel_pc;
                    end
                end
            end
            FETCH_HALT: begin
                w_state_nxt = FETCH_HALT;
            end
            default: begin
                w_state_nxt = FETCH_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FETCH_BOOT;
            r_pc_reg      <= RESET_PC;
            r_fetch_pc    <= RESET_PC;
            r_fetch_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_addr_error  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc_reg      <= w_pc_reg_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_fetch_valid <= w_fetch_valid_nxt;
            r_halted      <= w_halted_nxt;
            r_addr_error  <= w_addr_error_nxt;
        end
    end

    always_comb begin
        read_address = r_pc_reg;
        if (rst) begin
            read_address = RESET_PC;
        end else if ((r_state == FETCH_RUN && stall) || r_state == FETCH_HALT) begin
            read_address = r_fetch_pc;
        end
    end

    assign fetch_pc    = r_fetch_pc;
    assign pc_plus4    = w_pc_plus4;
    assign fetch_valid = r_fetch_valid;
    assign halted      = r_halted;
    assign addr_error  = r_addr_error;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          IMEM_WORDS = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        halt_req = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_offset = '0;
    logic        jump = 1'b0;
    logic [25:0] jump_target = '0;
    logic        jump_reg = 1'b0;
    logic [31:0] jr_target = '0;
    logic [31:0] read_address;
    logic [31:0] fetch_pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        halted;
    logic        addr_error;

    fetch_pc_unit #(
        .RESET_PC   (RESET_PC),
        .IMEM_WORDS (IMEM_WORDS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .halt_req      (halt_req),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .jump_reg      (jump_reg),
        .jr_target     (jr_target),
        .read_address  (read_address),
        .fetch_pc      (fetch_pc),
        .pc_plus4      (pc_plus4),
        .fetch_valid   (fetch_valid),
        .halted        (halted),
        .addr_error    (addr_error)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: the current instruction plus a queue of words already requested from memory
    logic [31:0] m_cur;
    logic [31:0] m_requested[$];
    bit          m_booting, m_stopped, m_valid, m_err;
    bit          chk_en = 1'b0;

    function automatic bit bad_addr(input logic [31:0] a);
        return (a % 4 != 0) || (a >= IMEM_WORDS * 4);
    endfunction

    task automatic model_step();
        logic [31:0] tgt;
        logic [31:0] link;
        if (rst) begin
            m_booting = 1; m_stopped = 0; m_valid = 0; m_err = 0;
            m_cur = RESET_PC;
            m_requested.delete();
            m_requested.push_back(RESET_PC);
        end else if (m_booting) begin
            m_cur = m_requested.pop_front();
            m_requested.push_back(m_cur + 4);
            m_valid = 1; m_booting = 0;
        end else if (m_stopped || stall) begin
        end else if (halt_req) begin
            m_stopped = 1; m_valid = 0;
        end else begin
            link = m_cur + 4;
            if (jump_reg)          tgt = jr_target;
            else if (jump)         tgt = {link[31:28], jump_target, 2'b00};
            else if (branch_taken) tgt = link + branch_offset * 4;
            else                   tgt = m_requested[0] + 4;
            m_cur = m_requested.pop_front();
            if (bad_addr(tgt)) begin
                m_err = 1; m_stopped = 1; m_valid = 0;
                m_requested.push_back(m_cur);
            end else begin
                m_requested.push_back(tgt);
            end
        end
    endtask

    function automatic logic [31:0] model_raddr();
        if (rst) return RESET_PC;
        if (m_stopped || (!m_booting && stall)) return m_cur;
        return m_requested[0];
    endfunction

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            chk("read_address", read_address, model_raddr());
            chk("fetch_pc", fetch_pc, m_cur);
            chk("pc_plus4", pc_plus4, m_cur + 32'd4);
            chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_valid});
            chk("halted", {31'd0, halted}, {31'd0, m_stopped});
            chk("addr_error", {31'd0, addr_error}, {31'd0, m_err});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        stall = 0; halt_req = 0; branch_taken = 0; branch_offset = '0;
        jump = 0; jump_target = '0; jump_reg = 0; jr_target = '0;
    endtask

    task automatic reset_and_boot();
        rst = 1; clear_ctl();
        tick(); tick();
        rst = 0;
        tick();
    endtask

    initial begin
        rst = 1;
        tick();
        chk_en = 1;
        tick();
        chk("reset fetch_valid", {31'd0, fetch_valid}, 32'd0);
        chk("reset fetch_pc", fetch_pc, 32'h0);
        chk("reset pc_plus4", pc_plus4, 32'h4);
        chk("reset read_address", read_address, 32'h0);
        rst = 0;
        tick();
        chk("boot fetch_valid", {31'd0, fetch_valid}, 32'd1);
        chk("boot fetch_pc", fetch_pc, 32'h0);
        chk("boot read_address", read_address, 32'h4);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("seq fetch_pc", fetch_pc, 32'(i * 4));
        end
        chk("seq read_address", read_address, 32'h14);

        branch_taken = 1; branch_offset = -32'sd3;
        tick(); clear_ctl();
        chk("branch slot", fetch_pc, 32'h14);
        tick();
        chk("branch target", fetch_pc, 32'h08);
        tick();
        chk("branch follow", fetch_pc, 32'h0C);

        while (fetch_pc != 32'h20 && n_total < 2000) tick();
        jump = 1; jump_target = 26'h10; jump_reg = 1; jr_target = 32'h40;
        tick(); clear_ctl();
        chk("jr slot", fetch_pc, 32'h24);
        tick();
        chk("jr target", fetch_pc, 32'h40);

        jump = 1; jump_target = 26'h2;
        tick(); clear_ctl();
        tick();
        chk("jump target", fetch_pc, 32'h08);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall fetch_pc", fetch_pc, 32'h08);
            chk("stall read_address", read_address, 32'h08);
        end
        stall = 0;
        tick();
        chk("unstall 1", fetch_pc, 32'h0C);
        tick();
        chk("unstall 2", fetch_pc, 32'h10);

        jump_reg = 1; jr_target = 32'h22;
        tick(); clear_ctl();
        chk("jr err fetch_pc", fetch_pc, 32'h14);
        chk("jr err flag", {31'd0, addr_error}, 32'd1);
        chk("jr err halted", {31'd0, halted}, 32'd1);
        tick(); tick();

        reset_and_boot();
        jump = 1; jump_target = 26'h7D;
        tick(); clear_ctl();
        tick();
        chk("jump far", fetch_pc, 32'h1F4);
        tick(); tick();
        chk("end fetch_pc", fetch_pc, 32'h1FC);
        chk("end addr_error", {31'd0, addr_error}, 32'd1);
        chk("end fetch_valid", {31'd0, fetch_valid}, 32'd0);
        tick();
        chk("end frozen", fetch_pc, 32'h1FC);

        reset_and_boot();
        tick(); tick(); tick();
        chk("pre-halt", fetch_pc, 32'h0C);
        halt_req = 1; branch_taken = 1; branch_offset = 32'd8;
        tick(); clear_ctl();
        for (int i = 0; i < 5; i++) begin
            jump = 1; jump_target = 26'h3;
            tick();
            chk("halt fetch_pc", fetch_pc, 32'h0C);
            chk("halt read_address", read_address, 32'h0C);
            chk("halt halted", {31'd0, halted}, 32'd1);
        end
        clear_ctl();
        rst = 1;
        tick();
        chk("halt reset valid", {31'd0, fetch_valid}, 32'd0);
        chk("halt reset pc", fetch_pc, 32'h0);
        rst = 0;
        tick();
        chk("rerun valid", {31'd0, fetch_valid}, 32'd1);
        chk("rerun fetch_pc", fetch_pc, 32'h0);

        stall = 1;
        tick();
        rst = 1;
        tick();
        rst = 0; stall = 0;
        tick();
        chk("stall reset fetch_pc", fetch_pc, 32'h0);
        tick();
        chk("stall reset next", fetch_pc, 32'h4);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
